// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit:
//   - RISC-V funct3 width/sign codes for loads (LB/LH/LW/LBU/LHU) and
//     stores (SB/SH/SW)
//   - the unit's state enumeration
//   - small helpers that decode legality, alignment and store lane layout
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

  // Load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic load_legal(input logic [2:0] f3);
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

  function automatic logic store_legal(input logic [2:0] f3);
    return (f3 == SB) || (f3 == SH) || (f3 == SW);
  endfunction

  // Loads and stores share the size encoding in funct3[1:0]
  // (00 byte, 01 half, 10 word), so one check covers both.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = offset[0];
      2'b10:   bad = (offset != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Byte-enable pattern for a store, positioned at the byte offset.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] offset);
    logic [3:0] mask;
    case (f3[1:0])
      2'b00:   mask = 4'b0001 << offset;
      2'b01:   mask = 4'b0011 << offset;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Replicate the right-aligned store data across every lane it could
  // land in, so the byte enables alone select the destination.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational extract/extend of a load result from a 32-bit BRAM word.
//   rdata  [31:0] : raw word from the BRAM
//   offset [1:0]  : byte offset of the access inside the word
//   funct3 [2:0]  : load width/sign code (LB/LH/LW/LBU/LHU)
//   result [31:0] : right-aligned, sign- or zero-extended load data
// -----------------------------------------------------------------------------
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  assign byte_sel = lane[offset];
  // Halves are only ever legal at offsets 0 and 2.
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result = {24'd0, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LHU:     result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store unit in front of a single-port BRAM with a
// READ_LAT-cycle registered read (1 or 2). Stores finish in their accept
// cycle; loads stall the pipeline (MemBusy) for READ_LAT+1 cycles and then
// deliver an aligned, extended result with a one-cycle ReadValidM pulse.
//
// Ports
//   clk, reset             : clock, synchronous active-low reset
//   MemReqM                : access request valid
//   MemWriteM              : 1 = store, 0 = load
//   Funct3M [2:0]          : RISC-V width/sign code
//   AddrM [31:0]           : byte address
//   WriteDataM [31:0]      : right-aligned store data
//   ReadDataM [31:0]       : registered load result, held until next load
//   ReadValidM             : one-cycle pulse with each new load result
//   MemBusy                : stall request to the hazard unit
//   MisalignM              : one-cycle flag for a rejected access
//   bram_en, bram_we[3:0]  : BRAM enable and byte write enables
//   bram_addr [ADDR_W-1:0] : BRAM word address
//   bram_wdata [31:0]      : lane-replicated write data
//   bram_rdata [31:0]      : BRAM read data, READ_LAT cycles after enable
// -----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       AddrM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              ReadValidM,
  output logic              MemBusy,
  output logic              MisalignM,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata
);

  // Last value of the WAIT counter before the read data is captured.
  localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

  lsu_state_t  state_reg;
  logic [1:0]  wait_cnt_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic [31:0] read_data_reg;
  logic        read_valid_reg;

  logic        can_accept;
  logic        accept;
  logic        legal;
  logic        reject;
  logic        store_go;
  logic        load_go;
  logic [31:0] aligned;

  // ---------------------------------------------------------------------------
  // Accept / reject decode (all gated by reset so outputs are quiet in reset)
  // ---------------------------------------------------------------------------
  assign can_accept = (state_reg == IDLE) || (state_reg == DONE);
  assign accept     = reset && MemReqM && can_accept;
  assign legal      = MemWriteM ? store_legal(Funct3M) : load_legal(Funct3M);
  assign reject     = accept && (!legal || misaligned(Funct3M, AddrM[1:0]));
  assign store_go   = accept && !reject && MemWriteM;
  assign load_go    = accept && !reject && !MemWriteM;

  // ---------------------------------------------------------------------------
  // Combinational outputs
  // ---------------------------------------------------------------------------
  assign MisalignM  = reject;
  // Stall starts in the accept cycle and covers every WAIT cycle.
  assign MemBusy    = load_go || (reset && (state_reg == WAIT));
  assign bram_en    = store_go || load_go;
  assign bram_we    = store_go ? store_mask(Funct3M, AddrM[1:0]) : 4'b0000;
  // Upper address bits are dropped, so out-of-range addresses wrap.
  assign bram_addr  = reset ? AddrM[ADDR_W+1:2] : '0;
  assign bram_wdata = reset ? store_lanes(Funct3M, WriteDataM) : 32'd0;

  assign ReadDataM  = read_data_reg;
  assign ReadValidM = read_valid_reg;

  if (ADDR_W + 2 < 32) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^AddrM[31:ADDR_W+2];
  end

  // ---------------------------------------------------------------------------
  // Extract/extend from the BRAM word using the latched access shape
  // ---------------------------------------------------------------------------
  load_align u_load_align (
    .rdata  (bram_rdata),
    .offset (offset_reg),
    .funct3 (funct3_reg),
    .result (aligned)
  );

  // ---------------------------------------------------------------------------
  // State machine with registered load result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 2'd0;
      funct3_reg     <= 3'd0;
      offset_reg     <= 2'd0;
      read_data_reg  <= 32'd0;
      read_valid_reg <= 1'b0;
    end else begin
      read_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          // DONE behaves like IDLE so back-to-back loads need no bubble.
          if (load_go) begin
            funct3_reg   <= Funct3M;
            offset_reg   <= AddrM[1:0];
            wait_cnt_reg <= 2'd0;
            state_reg    <= WAIT;
          end else begin
            state_reg    <= IDLE;
          end
        end
        WAIT: begin
          // MemReqM is ignored here: the stalled pipeline holds it stable.
          if (wait_cnt_reg == WAIT_LAST) begin
            read_data_reg  <= aligned;
            read_valid_reg <= 1'b1;
            state_reg      <= DONE;
          end else begin
            wait_cnt_reg   <= wait_cnt_reg + 2'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving the BRAM word-address width.
REQ-002 SHALL have parameter READ_LAT, default 1, giving the BRAM read latency in cycles; legal values are 1 and 2.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 MemReqM  input  1  Memory-stage access request valid.
REQ-006 MemWriteM  input  1  store (1) or load (0).
REQ-007 Funct3M  input  3  RISC-V width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 AddrM  input  32  byte address.
REQ-009 WriteDataM  input  32  store data, right-aligned.
REQ-010 ReadDataM  output  32  registered, aligned and extended load result.
REQ-011 ReadValidM  output  1  one-cycle pulse: ReadDataM holds a new result.
REQ-012 MemBusy  output  1  stall request to the hazard unit; it holds stages F/D/E/M.
REQ-013 MisalignM  output  1  one-cycle flag: misaligned or illegal access rejected.
REQ-014 bram_en  output  1  BRAM enable.
REQ-015 bram_we  output  4  per-byte write enable.
REQ-016 bram_addr  output  ADDR_W  word address.
REQ-017 bram_wdata  output  32  write data, lane-replicated.
REQ-018 bram_rdata  input  32  BRAM read data, valid READ_LAT cycles after the enable.

Function
REQ-019 The unit SHALL use states IDLE, WAIT and DONE.
REQ-020 The unit SHALL accept a request only when MemReqM=1 and the state is IDLE or DONE.
REQ-021 bram_addr SHALL equal AddrM[ADDR_W+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
REQ-022 Misaligned accesses SHALL be rejected:
- LH, LHU or SH with AddrM[0]=1;
- LW or SW with AddrM[1:0]!=0.
REQ-023 Illegal funct3 codes SHALL be rejected: load codes 011/110/111, and store codes other than 000/001/010.
REQ-024 A rejected access SHALL assert MisalignM combinationally in the accept cycle, with no BRAM access and no MemBusy.
REQ-025 An accepted store SHALL complete in one cycle:
- bram_en=1;
- bram_we = 0001, 0011 or 1111, shifted left by AddrM[1:0] for byte and half stores;
- bram_wdata = the byte replicated x4, the half replicated x2, or the word;
- no MemBusy;
- the state goes to IDLE.
REQ-026 An accepted load in cycle T SHALL behave as follows:
- bram_en=1 and bram_we=0 in cycle T;
- Funct3M and AddrM[1:0] are latched;
- the state goes to WAIT.
REQ-027 MemBusy SHALL be 1 from cycle T through T+READ_LAT, asserted combinationally in T, giving READ_LAT+1 stall cycles.
REQ-028 WAIT SHALL count READ_LAT-1 extra cycles with a counter.
REQ-029 At the end of cycle T+READ_LAT, the unit SHALL extract the byte/half at the latched offset from bram_rdata and store it in ReadDataM:
- LB and LH are sign-extended;
- LBU and LHU are zero-extended.
REQ-030 The state SHALL then go to DONE.
REQ-031 In DONE, ReadValidM=1 and MemBusy=0.
REQ-032 ReadDataM SHALL hold its value until the next load completes.
REQ-033 A request in DONE SHALL be accepted exactly as in IDLE (back-to-back loads allowed).
REQ-034 With no request in DONE, the state SHALL go to IDLE.
REQ-035 MemReqM SHALL be ignored in WAIT; the held pipeline keeps it stable.
REQ-036 bram_en and bram_we SHALL be 0 in every cycle not listed above.

Reset
REQ-037 While reset=0 at a clock edge, the state SHALL become IDLE and the WAIT counter SHALL clear.
REQ-038 While reset=0 at a clock edge, ReadDataM=0 and ReadValidM=0.
REQ-039 During reset, MemBusy, MisalignM, bram_en, bram_we, bram_addr and bram_wdata SHALL be 0.
REQ-040 Reset during WAIT or DONE SHALL discard the pending load; no ReadValidM pulse follows.

Structure
REQ-041 A shared package SHALL hold:
- the funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW;
- the state enumeration.
REQ-042 The combinational extract/extend logic SHALL be one sub-module, load_align, with inputs rdata, offset and funct3, and output result.

Verification
REQ-043 SB at 0x0000_0006 with data 0x0000_00A5 -> one cycle with bram_we=0100, bram_addr=1, bram_wdata=0xA5A5A5A5, MemBusy=0.
REQ-044 LB at 0x0000_0003 with bram_rdata=0x80FF_1234 (READ_LAT=1) -> MemBusy high 2 cycles, then ReadValidM pulse with ReadDataM=0xFFFF_FF80.
REQ-045 LHU at 0x0000_0002, same data -> ReadDataM=0x0000_80FF; LW at 0x0000_0001 -> MisalignM=1 one cycle, bram_en=0, MemBusy=0.
REQ-046 Back-to-back loads:
- stimulus: LW 0x0 then LW 0x4, with the second presented in DONE and READ_LAT=2;
- response: each MemBusy window lasts 3 cycles;
- response: ReadValidM pulses exactly twice with the correct words.
REQ-047 reset=0 asserted during WAIT -> no ReadValidM pulse, ReadDataM=0, state IDLE; the next SW at 0x8 completes normally.
